clkphase_ctrl: RTL and testbench

- Phase controller directly upstream of the DTB clock generator; sole driver of its `shift` input.
- Accepts a target phase (in clk cycles) over a valid/ready handshake. Issues the exact number of one-cycle `shift` holds needed to move the divided ROC clock to that phase, then reports completion.
- Tracks the accumulated phase offset so software can request absolute phases without knowing history.

---
 rtl/clkphase_ctrl_if.sv | 9 +
 rtl/clkphase_ctrl.sv | 114 +++++++++++
 tb/tb_clkphase_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/clkphase_ctrl_if.sv
// Request channel into the phase controller: absolute target phase with valid/ready.
interface clkphase_ctrl_if;
  logic [5:0] set_phase;
  logic       set_valid;
  logic       set_ready;

  modport master (output set_phase, output set_valid, input  set_ready);
  modport slave  (input  set_phase, input  set_valid, output set_ready);
endinterface

// File: rtl/clkphase_ctrl.sv
// Phase controller feeding the DTB clock generator's shift input; tracks absolute phase mod 64.
// Optional post-shift settle window enabled by defining CLKPHASE_SETTLE_EN.
module clkphase_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [5:0]         clkdiv_i,
  clkphase_ctrl_if.slave     req_if,
  output logic               shift_o,
  output logic               busy_o,
  output logic               done_o,
  output logic [5:0]         cur_phase_o
);

  // One counter serves both the shift run (max 63) and the settle window.
  localparam int unsigned CNT_W = (SETTLE_CYCLES > 63) ? 8 : 6;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_FINISH = 2'd2;
`ifdef CLKPHASE_SETTLE_EN
  localparam logic [1:0]       ST_SETTLE = 2'd3;
  localparam logic [1:0]       ST_POST   = ST_SETTLE;
  localparam logic [CNT_W-1:0] POST_LD   = CNT_W'(SETTLE_CYCLES);
`else
  localparam logic [1:0]       ST_POST   = ST_FINISH;
  localparam logic [CNT_W-1:0] POST_LD   = '0;
`endif

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [5:0]       cur_phase_q, cur_phase_d;
  logic             shift_q, busy_q, done_q, ready_q;

  logic [2:0]       k;
  logic [6:0]       mask_w;
  logic [5:0]       mask;
  logic [5:0]       steps;
  logic             accept;
  logic             unused_clkdiv;

  assign unused_clkdiv = ^clkdiv_i[5:3];

  // k = 5 covers the full 6-bit range; the wider intermediate avoids 2<<5 overflowing.
  assign k      = (clkdiv_i[2:0] > 3'd5) ? 3'd5 : clkdiv_i[2:0];
  assign mask_w = (7'd2 << k) - 7'd1;
  assign mask   = mask_w[5:0];
  assign steps  = (req_if.set_phase - cur_phase_q) & mask;
  assign accept = req_if.set_valid & ready_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cur_phase_d = cur_phase_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (steps != 6'd0) begin
            state_d = ST_SHIFT;
            cnt_d   = CNT_W'(steps);
          end else begin
            state_d = ST_POST;
            cnt_d   = POST_LD;
          end
        end
      end
      ST_SHIFT: begin
        cur_phase_d = cur_phase_q + 6'd1;
        cnt_d       = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_POST;
          cnt_d   = POST_LD;
        end
      end
`ifdef CLKPHASE_SETTLE_EN
      ST_SETTLE: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = ST_FINISH;
      end
`endif
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so each one is a flop aligned with the state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      cur_phase_q <= 6'd0;
      shift_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cur_phase_q <= cur_phase_d;
      shift_q     <= (state_d == ST_SHIFT);
      busy_q      <= (state_d != ST_IDLE);
      done_q      <= (state_d == ST_FINISH);
      ready_q     <= (state_d == ST_IDLE);
    end
  end

  assign req_if.set_ready = ready_q;
  assign shift_o          = shift_q;
  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign cur_phase_o      = cur_phase_q;

endmodule

// File: tb/tb_clkphase_ctrl.sv
// Randomized bench for clkphase_ctrl against a cycle-indexed model of one request's timeline.
module tb_clkphase_ctrl;
`ifdef CLKPHASE_SETTLE_EN
  localparam int SETTLE = 16;
`else
  localparam int SETTLE = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] clkdiv = 6'd0;
  logic       shift, busy, done;
  logic [5:0] cur_phase;
  int         vecs = 0;
  int         errs = 0;
  int         cur_m = 0;

  clkphase_ctrl_if bus ();

  clkphase_ctrl #(.SETTLE_CYCLES(16)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .clkdiv_i    (clkdiv),
    .req_if      (bus),
    .shift_o     (shift),
    .busy_o      (busy),
    .done_o      (done),
    .cur_phase_o (cur_phase)
  );

  always #5 clk = ~clk;

  // Entered and left at a negedge. Cycle c counts from the cycle after the accept edge.
  task automatic test_request(input int phase, input int div, input bit glitch);
    int k, mask, steps, tot;
    k     = (div % 8 > 5) ? 5 : div % 8;
    mask  = (2 << k) - 1;
    steps = (phase - cur_m) & mask;
    tot   = steps + 1 + SETTLE;
    vecs++;
    if (bus.set_ready !== 1'b1) begin
      errs++; $display("FAIL ready_before_req got %b want 1", bus.set_ready);
    end
    bus.set_phase = 6'(phase);
    bus.set_valid = 1'b1;
    clkdiv        = 6'(div);
    @(posedge clk); #1;
    bus.set_valid = 1'b0;
    clkdiv        = 6'($urandom);
    for (int c = 1; c <= tot + 1; c++) begin
      @(negedge clk);
      vecs += 4;
      if (shift !== 1'(c <= steps)) begin
        errs++; $display("FAIL shift c=%0d steps=%0d got %b want %b", c, steps, shift, c <= steps);
      end
      if (done !== 1'(c == tot)) begin
        errs++; $display("FAIL done c=%0d steps=%0d got %b want %b", c, steps, done, c == tot);
      end
      if (busy !== 1'(c <= tot)) begin
        errs++; $display("FAIL busy c=%0d steps=%0d got %b want %b", c, steps, busy, c <= tot);
      end
      if (bus.set_ready !== 1'(c > tot)) begin
        errs++; $display("FAIL ready c=%0d steps=%0d got %b want %b", c, steps, bus.set_ready, c > tot);
      end
      if (glitch && steps >= 3 && c == 2) begin
        bus.set_valid = 1'b1;
        bus.set_phase = 6'($urandom);
      end
      if (glitch && steps >= 3 && c == 3) bus.set_valid = 1'b0;
    end
    cur_m = (cur_m + steps) % 64;
    vecs++;
    if (cur_phase !== 6'(cur_m)) begin
      errs++; $display("FAIL cur_phase got %0d want %0d", cur_phase, cur_m);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.set_valid = 1'b0;
    bus.set_phase = 6'd0;
    repeat (2) @(negedge clk);
    vecs += 5;
    if (shift !== 1'b0)          begin errs++; $display("FAIL rst_shift got %b want 0", shift); end
    if (busy !== 1'b0)           begin errs++; $display("FAIL rst_busy got %b want 0", busy); end
    if (done !== 1'b0)           begin errs++; $display("FAIL rst_done got %b want 0", done); end
    if (bus.set_ready !== 1'b1)  begin errs++; $display("FAIL rst_ready got %b want 1", bus.set_ready); end
    if (cur_phase !== 6'd0)      begin errs++; $display("FAIL rst_phase got %0d want 0", cur_phase); end
    rst_n = 1'b1;
    cur_m = 0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    test_request(5, 3, 1'b0);   // 5 steps
    test_request(2, 3, 1'b0);   // 13 steps -> 18
    test_request(0, 0, 1'b0);   // mask 1, already aligned
    test_request(60, 7, 1'b0);  // 42 steps -> 60
    test_request(3, 7, 1'b0);   // 7 steps with 63->0 wrap
  endtask

  task automatic test_ignore_valid();
    test_request(cur_m + 9, 5, 1'b1);
    test_request(cur_m + 20, 6, 1'b1);
  endtask

  task automatic test_reset_mid_shift();
    bus.set_phase = 6'(cur_m + 40);
    bus.set_valid = 1'b1;
    clkdiv        = 6'd7;
    @(posedge clk); #1;
    bus.set_valid = 1'b0;
    repeat (3) @(negedge clk);
    vecs++;
    if (shift !== 1'b1) begin errs++; $display("FAIL midshift_pre got %b want 1", shift); end
    #2 rst_n = 1'b0;
    #1;
    vecs += 4;
    if (shift !== 1'b0)         begin errs++; $display("FAIL abort_shift got %b want 0", shift); end
    if (cur_phase !== 6'd0)     begin errs++; $display("FAIL abort_phase got %0d want 0", cur_phase); end
    if (busy !== 1'b0)          begin errs++; $display("FAIL abort_busy got %b want 0", busy); end
    if (bus.set_ready !== 1'b1) begin errs++; $display("FAIL abort_ready got %b want 1", bus.set_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    cur_m = 0;
    repeat (2) @(negedge clk);
    vecs += 3;
    if (shift !== 1'b0)         begin errs++; $display("FAIL post_rst_shift got %b want 0", shift); end
    if (cur_phase !== 6'd0)     begin errs++; $display("FAIL post_rst_phase got %0d want 0", cur_phase); end
    if (bus.set_ready !== 1'b1) begin errs++; $display("FAIL post_rst_ready got %b want 1", bus.set_ready); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++)
      test_request(int'($urandom_range(0, 63)), int'($urandom_range(0, 63)), 1'($urandom));
  endtask

  task automatic test_back_to_back();
    test_request(cur_m + 1, 2, 1'b0);
    test_request(cur_m, 2, 1'b0);
    test_request(cur_m + 63, 5, 1'b0);
  endtask

  initial begin
    bus.set_valid = 1'b0;
    bus.set_phase = 6'd0;
    test_reset();
    test_directed();
    test_ignore_valid();
    test_back_to_back();
    test_reset_mid_shift();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
